// File: rtl/seq_stim_tx.sv
// Serial transmitter for the single-bit "A" link: shifts WIDTH-bit words out LSB-first and
// mirrors the phase/parity receiver so y_exp tracks the Y the receiver must show.
module seq_stim_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             a_out_o,
  output logic             a_valid_o,
  output logic             last_o,
  output logic             done_o,
  output logic             y_exp_o
);

  // Guarded so an illegal WIDTH reaches the check below instead of a zero-width counter.
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("seq_stim_tx: WIDTH must be in 2..32");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              a_out_q, a_out_d;
  logic              a_valid_q, a_valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              q0m_q, q1m_q;
  logic              final_bit;
  logic              accept;

  assign final_bit  = (state_q == StShift) && (cnt_q == '0);
  assign in_ready_o = (state_q == StIdle) || final_bit;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    a_out_d   = a_out_q;
    a_valid_d = a_valid_q;
    last_d    = last_q;
    done_d    = final_bit;

    if (accept) begin
      // Same load path from IDLE and from the final bit, which gives gapless back-to-back words.
      state_d   = StShift;
      a_out_d   = in_data_i[0];
      shreg_d   = in_data_i >> 1;
      cnt_d     = CntW'(WIDTH - 1);
      a_valid_d = 1'b1;
      last_d    = 1'b0;
    end else if (state_q == StShift) begin
      if (cnt_q != '0) begin
        a_out_d = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - CntW'(1);
        last_d  = (cnt_q == CntW'(1));
      end else begin
        state_d   = StIdle;
        a_out_d   = IDLE_BIT;
        a_valid_d = 1'b0;
        last_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      a_out_q   <= IDLE_BIT;
      a_valid_q <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      a_out_q   <= a_out_d;
      a_valid_q <= a_valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  // Receiver mirror runs every cycle, idle or not, exactly like the real receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0m_q <= 1'b0;
      q1m_q <= 1'b0;
    end else begin
      q0m_q <= ~q0m_q;
      q1m_q <= a_out_q ^ q1m_q ^ q0m_q;
    end
  end

  assign a_out_o   = a_out_q;
  assign a_valid_o = a_valid_q;
  assign last_o    = last_q;
  assign done_o    = done_q;
  assign y_exp_o   = q0m_q & q1m_q;

endmodule

// File: tb/tb_seq_stim_tx.sv
// Directed and random bench for seq_stim_tx: bit scoreboard on a_out/last, a done predictor and a
// reference receiver compared against y_exp every cycle.
module tb_seq_stim_tx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         a_out;
  logic         a_valid;
  logic         last;
  logic         done;
  logic         y_exp;

  seq_stim_tx #(
    .WIDTH    (W),
    .IDLE_BIT (1'b0)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .a_out_o    (a_out),
    .a_valid_o  (a_valid),
    .last_o     (last),
    .done_o     (done),
    .y_exp_o    (y_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_stalls;
  logic prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference receiver driven by a_out.
  logic rq0, rq1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq0 <= 1'b0;
      rq1 <= 1'b0;
    end else begin
      rq0 <= ~rq0;
      rq1 <= a_out ^ rq1 ^ rq0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_a_valid", a_valid, 1'b0);
      chk("rst_last", last, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_y_exp", y_exp, 1'b0);
      prev_last = 1'b0;
    end else begin
      chk("y_exp_vs_receiver", y_exp, rq0 & rq1);
      chk("done", done, prev_last);
      if (a_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_bit", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("a_out", a_out, e.b);
          chk("last", last, e.l);
        end
      end else begin
        chk("idle_a_out", a_out, 1'b0);
        chk("idle_last", last, 1'b0);
      end
      prev_last = last & a_valid;
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after the accepting edge.
  task automatic send(input logic [W-1:0] w, input bit wiggle);
    int n = 0;
    in_valid = 1'b1;
    in_data  = wiggle ? W'($urandom) : w;
    while (!in_ready) begin
      if (n >= 64) begin
        chk("accept_timeout", 1'b1, 1'b0);
        break;
      end
      n++;
      if (wiggle) in_data = W'($urandom);
      @(negedge clk);
    end
    in_data = w;
    for (int i = 0; i < W; i++) sb.push_back('{b: w[i], l: (i == W - 1)});
    @(negedge clk);
    last_stalls = n;
  endtask

  initial begin
    logic [7:0] ypat;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ypat;
    ypat     = 8'b1000_1000;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset and idle: y_exp follows 0,0,0,1 with a_out parked.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      chk("idle_y_pattern", y_exp, ypat[i]);
      chk("idle_a_valid", a_valid, 1'b0);
      chk("idle_in_ready", in_ready, 1'b1);
    end

    // Single word A5.
    @(negedge clk);
    send(8'hA5, 1'b0);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("a5_done_k9", done, 1'b1);
    chk("a5_a_valid_k9", a_valid, 1'b0);
    @(negedge clk);
    chk("a5_done_k10", done, 1'b0);

    // Back-to-back FF then 00 with in_valid held high.
    send(8'hFF, 1'b0);
    for (int j = 0; j < 7; j++) begin
      chk("b2b_a_valid", a_valid, 1'b1);
      chk("b2b_ready_low", in_ready, 1'b0);
      @(negedge clk);
    end
    chk("b2b_a_valid", a_valid, 1'b1);
    send(8'h00, 1'b0);
    in_valid = 1'b0;
    chk("b2b_no_stall", last_stalls, 0);
    for (int j = 8; j < 16; j++) begin
      chk("b2b_a_valid", a_valid, 1'b1);
      chk("b2b_ready", in_ready, (j == 15));
      @(negedge clk);
    end
    chk("b2b_end_a_valid", a_valid, 1'b0);

    // Stalled request with wiggling data; value at the accepting edge must be sent.
    repeat (2) @(negedge clk);
    send(8'h12, 1'b0);
    send(8'h3C, 1'b1);
    in_valid = 1'b0;
    chk("stall_cycles", last_stalls, 7);
    repeat (10) @(negedge clk);

    // Reset mid-word after bit 3.
    send(8'h96, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_a_out", a_out, 1'b0);
    chk("midrst_a_valid", a_valid, 1'b0);
    chk("midrst_y_exp", y_exp, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(8'h69, 1'b0);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_sb_drained", sb.size(), 0);

    // Random words, mix of gapless and gapped traffic.
    for (int k = 0; k < 110; k++) begin
      send(W'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat (7 + $urandom_range(0, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("random_sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
